ex_mem_pipe: RTL and testbench

//  EX->MEM pipeline register feeding the data-memory stage: captures ALU result, store data,

---
 rtl/ex_mem_pipe.sv | 104 ++++++++++
 tb/tb_ex_mem_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with stall/flush handling and halt sequencing.
// A committed halt raises createdump for one cycle, then freezes the stage as a bubble.
module ex_mem_pipe #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     ex_ALU_out,
    input  logic [DATA_W-1:0]     ex_data_2,
    input  logic                  ex_write_mem,
    input  logic                  ex_read_mem,
    input  logic                  ex_reg_wr,
    input  logic [REG_ADDR_W-1:0] ex_wr_reg,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_halt,
    input  logic                  ex_valid,
    input  logic                  stall,
    input  logic                  flush,
    output logic [DATA_W-1:0]     ALU_out,
    output logic [DATA_W-1:0]     data_2,
    output logic                  write_mem,
    output logic                  read_mem,
    output logic                  reg_wr,
    output logic [REG_ADDR_W-1:0] wr_reg,
    output logic                  mem_to_reg,
    output logic                  valid,
    output logic                  createdump,
    output logic                  halted
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DUMP   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;
    logic   halt_q;

    // createdump/halted are registered alongside the state so they never see an input path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            ALU_out    <= '0;
            data_2     <= '0;
            write_mem  <= 1'b0;
            read_mem   <= 1'b0;
            reg_wr     <= 1'b0;
            wr_reg     <= '0;
            mem_to_reg <= 1'b0;
            halt_q     <= 1'b0;
            valid      <= 1'b0;
            createdump <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if ((valid && halt_q) || flush) begin
                        // A halt reaching MEM wins over everything and starts the dump sequence.
                        if (valid && halt_q) begin
                            state      <= DUMP;
                            createdump <= 1'b1;
                        end
                        ALU_out    <= '0;
                        data_2     <= '0;
                        write_mem  <= 1'b0;
                        read_mem   <= 1'b0;
                        reg_wr     <= 1'b0;
                        wr_reg     <= '0;
                        mem_to_reg <= 1'b0;
                        halt_q     <= 1'b0;
                        valid      <= 1'b0;
                    end else if (!stall) begin
                        ALU_out    <= ex_ALU_out;
                        data_2     <= ex_data_2;
                        wr_reg     <= ex_wr_reg;
                        write_mem  <= ex_write_mem  & ex_valid;
                        read_mem   <= ex_read_mem   & ex_valid;
                        reg_wr     <= ex_reg_wr     & ex_valid;
                        mem_to_reg <= ex_mem_to_reg & ex_valid;
                        halt_q     <= ex_halt       & ex_valid;
                        valid      <= ex_valid;
                    end
                end
                DUMP: begin
                    state      <= HALTED;
                    createdump <= 1'b0;
                    halted     <= 1'b1;
                end
                HALTED: begin
                    createdump <= 1'b0;
                    halted     <= 1'b1;
                end
                default: begin
                    state      <= HALTED;
                    createdump <= 1'b0;
                    halted     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: a cycle-level reference model checked every negedge,
// plus literal expectations at the interesting points of each scenario.
module tb_ex_mem_pipe;
    localparam int DW = 16;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] ex_ALU_out = '0, ex_data_2 = '0;
    logic          ex_write_mem = 0, ex_read_mem = 0, ex_reg_wr = 0, ex_mem_to_reg = 0;
    logic [RW-1:0] ex_wr_reg = '0;
    logic          ex_halt = 0, ex_valid = 0, stall = 0, flush = 0;

    logic [DW-1:0] ALU_out, data_2;
    logic          write_mem, read_mem, reg_wr, mem_to_reg, valid, createdump, halted;
    logic [RW-1:0] wr_reg;

    ex_mem_pipe #(.DATA_W(DW), .REG_ADDR_W(RW)) dut (
        .clk(clk), .rst(rst),
        .ex_ALU_out(ex_ALU_out), .ex_data_2(ex_data_2),
        .ex_write_mem(ex_write_mem), .ex_read_mem(ex_read_mem), .ex_reg_wr(ex_reg_wr),
        .ex_wr_reg(ex_wr_reg), .ex_mem_to_reg(ex_mem_to_reg), .ex_halt(ex_halt),
        .ex_valid(ex_valid), .stall(stall), .flush(flush),
        .ALU_out(ALU_out), .data_2(data_2), .write_mem(write_mem), .read_mem(read_mem),
        .reg_wr(reg_wr), .wr_reg(wr_reg), .mem_to_reg(mem_to_reg), .valid(valid),
        .createdump(createdump), .halted(halted)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the MEM slot content plus a count of cycles since the halt left MEM.
    logic [DW-1:0] m_alu, m_d2;
    logic          m_wm, m_rm, m_rw, m_m2r, m_halt, m_valid;
    logic [RW-1:0] m_wr;
    int            halt_age;

    task automatic m_clear();
        m_alu = '0; m_d2 = '0; m_wm = 0; m_rm = 0; m_rw = 0; m_m2r = 0;
        m_halt = 0; m_valid = 0; m_wr = '0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_clear();
            halt_age = 0;
        end else if (halt_age > 0) begin
            if (halt_age < 2) halt_age++;
        end else if (m_valid && m_halt) begin
            m_clear();
            halt_age = 1;
        end else if (flush) begin
            m_clear();
        end else if (!stall) begin
            m_alu   = ex_ALU_out;
            m_d2    = ex_data_2;
            m_wr    = ex_wr_reg;
            m_valid = ex_valid;
            m_wm    = ex_valid ? ex_write_mem  : 1'b0;
            m_rm    = ex_valid ? ex_read_mem   : 1'b0;
            m_rw    = ex_valid ? ex_reg_wr     : 1'b0;
            m_m2r   = ex_valid ? ex_mem_to_reg : 1'b0;
            m_halt  = ex_valid ? ex_halt       : 1'b0;
        end
    end

    always @(negedge clk) begin
        check("ALU_out",    ALU_out,    m_alu);
        check("data_2",     data_2,     m_d2);
        check("write_mem",  write_mem,  m_wm);
        check("read_mem",   read_mem,   m_rm);
        check("reg_wr",     reg_wr,     m_rw);
        check("wr_reg",     wr_reg,     m_wr);
        check("mem_to_reg", mem_to_reg, m_m2r);
        check("valid",      valid,      m_valid);
        check("createdump", createdump, halt_age == 1);
        check("halted",     halted,     halt_age >= 2);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] d, input logic wm,
                         input logic rm, input logic rwr, input logic [RW-1:0] wr,
                         input logic m2r, input logic h, input logic v);
        ex_ALU_out = a; ex_data_2 = d; ex_write_mem = wm; ex_read_mem = rm;
        ex_reg_wr = rwr; ex_wr_reg = wr; ex_mem_to_reg = m2r; ex_halt = h; ex_valid = v;
    endtask

    typedef struct {
        logic [DW-1:0] a, d;
        logic wm, rm, rwr;
        logic [RW-1:0] wr;
        logic m2r, v;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{16'h0001, 16'h0002, 0, 1, 1, 3'd1, 1, 1};
        tbl[1] = '{16'hFFFF, 16'h0000, 0, 0, 1, 3'd7, 0, 1};
        tbl[2] = '{16'h8000, 16'h7FFF, 1, 1, 0, 3'd4, 0, 1};
        tbl[3] = '{16'hA5A5, 16'h5A5A, 1, 1, 1, 3'd6, 1, 0};
        tbl[4] = '{16'h0000, 16'hFFFF, 1, 0, 0, 3'd0, 0, 1};
        tbl[5] = '{16'h1357, 16'h2468, 0, 1, 1, 3'd5, 1, 1};

        repeat (2) tick();
        check("reset_valid", valid, 0);
        check("reset_halted", halted, 0);
        check("reset_alu", ALU_out, 0);
        #3 rst = 1'b1;

        // Plain capture
        drive(16'h1234, 16'hBEEF, 1, 0, 0, 3'd2, 0, 0, 1);
        tick();
        check("t1_alu", ALU_out, 16'h1234);
        check("t1_data2", data_2, 16'hBEEF);
        check("t1_write_mem", write_mem, 1);
        check("t1_valid", valid, 1);

        // Stall holds for three cycles despite changing inputs
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(16'h4000 + 16'(i), 16'h0F00 + 16'(i), 0, 1, 1, 3'(i), 1, 0, 1);
            tick();
            check("t2_hold_alu", ALU_out, 16'h1234);
            check("t2_hold_data2", data_2, 16'hBEEF);
        end
        stall = 0;

        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].a, tbl[i].d, tbl[i].wm, tbl[i].rm, tbl[i].rwr, tbl[i].wr,
                  tbl[i].m2r, 0, tbl[i].v);
            tick();
        end
        check("tbl5_wr_reg", wr_reg, 3'd5);

        // Flush beats stall
        drive(16'h9999, 16'h8888, 1, 0, 1, 3'd3, 0, 0, 1);
        stall = 1; flush = 1;
        tick();
        check("t3_valid", valid, 0);
        check("t3_write_mem", write_mem, 0);
        check("t3_reg_wr", reg_wr, 0);
        stall = 0; flush = 0;

        // Invalid slot: controls gated, data still loads
        drive(16'h5555, 16'h6666, 1, 0, 1, 3'd3, 0, 0, 0);
        tick();
        check("t4_reg_wr", reg_wr, 0);
        check("t4_write_mem", write_mem, 0);
        check("t4_valid", valid, 0);
        check("t4_alu", ALU_out, 16'h5555);

        // A halt without ex_valid must not start the dump
        drive(16'h0, 16'h0, 0, 0, 0, 3'd0, 0, 1, 0);
        tick(); tick();
        check("inv_halt_dump", createdump, 0);
        check("inv_halt_halted", halted, 0);

        // Committed halt: captured at edge N
        drive(16'h00AA, 16'h00BB, 0, 0, 0, 3'd0, 0, 1, 1);
        tick();
        check("t5_n_valid", valid, 1);
        check("t5_n_dump", createdump, 0);
        drive(16'h7777, 16'h7777, 1, 0, 1, 3'd1, 0, 0, 1);
        stall = 1;
        tick();
        check("t5_n1_dump", createdump, 1);
        check("t5_n1_halted", halted, 0);
        check("t5_n1_valid", valid, 0);
        stall = 0;
        tick();
        check("t5_n2_dump", createdump, 0);
        check("t5_n2_halted", halted, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_frozen_wm", write_mem, 0);
            check("t5_frozen_halted", halted, 1);
        end

        // Async reset in the dump cycle
        rst = 0;
        tick();
        #3 rst = 1;
        drive(16'h00AA, 16'h0, 0, 0, 0, 3'd0, 0, 1, 1);
        tick();
        drive(16'h0, 16'h0, 0, 0, 0, 3'd0, 0, 0, 0);
        tick();
        check("t6_in_dump", createdump, 1);
        #2 rst = 0;
        #1;
        check("t6_rst_dump", createdump, 0);
        check("t6_rst_halted", halted, 0);
        check("t6_rst_valid", valid, 0);
        tick();
        #3 rst = 1;
        drive(16'hCAFE, 16'hF00D, 0, 1, 1, 3'd6, 1, 0, 1);
        tick();
        check("t6_resume_alu", ALU_out, 16'hCAFE);
        check("t6_resume_read_mem", read_mem, 1);
        check("t6_resume_halted", halted, 0);
        tick(); tick();
        check("t6_no_dump", createdump, 0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
